// File: rtl/rrv64_l1d_stride_pf_engine.sv
// L1D stride prefetch engine: per-PC stride training table, line generator and output request FIFO.
// Optional build macro RRV64_PF_DEDUP_EN suppresses candidates already queued or recently issued.
module rrv64_l1d_stride_pf_engine #(
    parameter int PF_ADDR_WIDTH        = 56,
    parameter int PF_ADDR_OFFSET_WIDTH = 6,
    parameter int PF_TRACK_TABLE_DEPTH = 4,
    parameter int PF_ENGINE_THRESHOLD  = 3,
    parameter int PF_ENGINE_STRIDE_NUM = 3,
    parameter int PF_REQ_BUFF_DEPTH    = 4,
    parameter int PF_PC_TAG_W          = 16,
    parameter int PF_STRIDE_W          = 12,
    parameter int PF_CONF_W            = 3,
    parameter int PF_PAGE_W            = 12
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          pf_en,
    input  logic                                          pf_flush,
    input  logic                                          train_vld,
    input  logic [PF_PC_TAG_W-1:0]                        train_pc,
    input  logic [PF_ADDR_WIDTH-1:0]                      train_addr,
    output logic                                          pf_req_vld,
    input  logic                                          pf_req_rdy,
    output logic [PF_ADDR_WIDTH-PF_ADDR_OFFSET_WIDTH-1:0] pf_req_line,
    output logic                                          pf_busy
);
    localparam int LW    = PF_ADDR_WIDTH - PF_ADDR_OFFSET_WIDTH;
    localparam int SW    = PF_STRIDE_W;
    localparam int CW    = PF_CONF_W;
    localparam int PG_LO = PF_PAGE_W - PF_ADDR_OFFSET_WIDTH;
    localparam int TIW   = (PF_TRACK_TABLE_DEPTH > 1) ? $clog2(PF_TRACK_TABLE_DEPTH) : 1;
    localparam int FPW   = (PF_REQ_BUFF_DEPTH > 1) ? $clog2(PF_REQ_BUFF_DEPTH) : 1;
    localparam int CNTW  = $clog2(PF_REQ_BUFF_DEPTH + 1);
    localparam int KW    = $clog2(PF_ENGINE_STRIDE_NUM + 1);

    localparam logic [0:0] GEN_IDLE = 1'b0;
    localparam logic [0:0] GEN_RUN  = 1'b1;

    // Training sample register: the table is looked up one cycle after the tap.
    logic                   trn_vld_q;
    logic [PF_PC_TAG_W-1:0] trn_pc_q;
    logic [LW-1:0]          trn_line_q;

    logic                   tbl_vld    [PF_TRACK_TABLE_DEPTH];
    logic [PF_PC_TAG_W-1:0] tbl_pc     [PF_TRACK_TABLE_DEPTH];
    logic [LW-1:0]          tbl_last   [PF_TRACK_TABLE_DEPTH];
    logic [SW-1:0]          tbl_stride [PF_TRACK_TABLE_DEPTH];
    logic [CW-1:0]          tbl_conf   [PF_TRACK_TABLE_DEPTH];
    logic [TIW-1:0]         rr_ptr;

    logic           hit, free_found, in_range, stride_match, do_train, trigger;
    logic [TIW-1:0] hit_idx, free_idx, alloc_idx;
    logic [LW-1:0]  delta;
    logic [SW-1:0]  new_stride;
    logic [CW-1:0]  new_conf;

    logic [0:0]        gen_state;
    logic [KW-1:0]     gen_k;
    logic [LW-1:0]     gen_cand, gen_stride_ext;
    logic [LW-PG_LO-1:0] gen_base_page;
    logic              gen_run, cand_cross, cand_dup, fifo_full, push, pop, advance;

    logic [LW-1:0]   fifo_mem [PF_REQ_BUFF_DEPTH];
    logic [FPW-1:0]  fifo_wr_ptr, fifo_rd_ptr;
    logic [CNTW-1:0] fifo_cnt;

    logic unused_addr_bits;
    assign unused_addr_bits = ^train_addr[PF_ADDR_OFFSET_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst || pf_flush) begin
            trn_vld_q  <= 1'b0;
            trn_pc_q   <= '0;
            trn_line_q <= '0;
        end else begin
            trn_vld_q  <= train_vld & pf_en;
            trn_pc_q   <= train_pc;
            trn_line_q <= train_addr[PF_ADDR_WIDTH-1:PF_ADDR_OFFSET_WIDTH];
        end
    end

    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < PF_TRACK_TABLE_DEPTH; i++) begin
            if (tbl_vld[i] && (tbl_pc[i] == trn_pc_q) && !hit) begin
                hit     = 1'b1;
                hit_idx = TIW'(i);
            end
            if (!tbl_vld[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = TIW'(i);
            end
        end
        alloc_idx = free_found ? free_idx : rr_ptr;
    end

    // A delta is usable only when its discarded upper bits are pure sign extension.
    always_comb begin
        delta        = trn_line_q - tbl_last[hit_idx];
        in_range     = (&delta[LW-1:SW-1]) | ~(|delta[LW-1:SW-1]);
        stride_match = in_range && (delta[SW-1:0] == tbl_stride[hit_idx]) && (delta[SW-1:0] != '0);
        new_stride   = stride_match ? tbl_stride[hit_idx] : (in_range ? delta[SW-1:0] : '0);
        new_conf     = '0;
        if (stride_match)
            new_conf = (&tbl_conf[hit_idx]) ? tbl_conf[hit_idx] : tbl_conf[hit_idx] + 1'b1;
        do_train = trn_vld_q & pf_en;
        trigger  = do_train & hit & (32'(new_conf) >= PF_ENGINE_THRESHOLD) & (gen_state == GEN_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PF_TRACK_TABLE_DEPTH; i++) begin
                tbl_vld[i]    <= 1'b0;
                tbl_pc[i]     <= '0;
                tbl_last[i]   <= '0;
                tbl_stride[i] <= '0;
                tbl_conf[i]   <= '0;
            end
            rr_ptr <= '0;
        end else if (pf_flush) begin
            for (int i = 0; i < PF_TRACK_TABLE_DEPTH; i++) tbl_vld[i] <= 1'b0;
            rr_ptr <= '0;
        end else if (do_train) begin
            if (hit) begin
                tbl_last[hit_idx]   <= trn_line_q;
                tbl_stride[hit_idx] <= new_stride;
                tbl_conf[hit_idx]   <= new_conf;
            end else begin
                tbl_vld[alloc_idx]    <= 1'b1;
                tbl_pc[alloc_idx]     <= trn_pc_q;
                tbl_last[alloc_idx]   <= trn_line_q;
                tbl_stride[alloc_idx] <= '0;
                tbl_conf[alloc_idx]   <= '0;
                rr_ptr <= (rr_ptr == TIW'(PF_TRACK_TABLE_DEPTH - 1)) ? '0 : rr_ptr + 1'b1;
            end
        end
    end

    // A pop in the same cycle frees a slot, so a full FIFO only stalls without one.
    assign pop        = pf_req_vld & pf_req_rdy;
    assign fifo_full  = (fifo_cnt == CNTW'(PF_REQ_BUFF_DEPTH)) & ~pop;
    assign gen_run    = (gen_state == GEN_RUN);
    assign cand_cross = (gen_cand[LW-1:PG_LO] != gen_base_page);
    assign advance    = gen_run & ~cand_cross & (cand_dup | ~fifo_full);
    assign push       = advance & ~cand_dup;

    always_ff @(posedge clk) begin
        if (rst) begin
            gen_state      <= GEN_IDLE;
            gen_k          <= '0;
            gen_cand       <= '0;
            gen_stride_ext <= '0;
            gen_base_page  <= '0;
        end else if (pf_flush || !pf_en) begin
            gen_state <= GEN_IDLE;
        end else if (gen_state == GEN_IDLE) begin
            if (trigger) begin
                gen_state      <= GEN_RUN;
                gen_k          <= KW'(1);
                gen_stride_ext <= {{(LW-SW){new_stride[SW-1]}}, new_stride};
                gen_cand       <= trn_line_q + {{(LW-SW){new_stride[SW-1]}}, new_stride};
                gen_base_page  <= trn_line_q[LW-1:PG_LO];
            end
        end else if (cand_cross) begin
            gen_state <= GEN_IDLE;
        end else if (advance) begin
            if (gen_k == KW'(PF_ENGINE_STRIDE_NUM)) begin
                gen_state <= GEN_IDLE;
            end else begin
                gen_k    <= gen_k + 1'b1;
                gen_cand <= gen_cand + gen_stride_ext;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || pf_flush) begin
            fifo_wr_ptr <= '0;
            fifo_rd_ptr <= '0;
            fifo_cnt    <= '0;
        end else begin
            if (push) begin
                fifo_mem[fifo_wr_ptr] <= gen_cand;
                fifo_wr_ptr <= (fifo_wr_ptr == FPW'(PF_REQ_BUFF_DEPTH - 1)) ? '0 : fifo_wr_ptr + 1'b1;
            end
            if (pop)
                fifo_rd_ptr <= (fifo_rd_ptr == FPW'(PF_REQ_BUFF_DEPTH - 1)) ? '0 : fifo_rd_ptr + 1'b1;
            fifo_cnt <= fifo_cnt + CNTW'(push) - CNTW'(pop);
        end
    end

`ifdef RRV64_PF_DEDUP_EN
    logic [LW-1:0]  hist_mem [PF_REQ_BUFF_DEPTH];
    logic           hist_vld [PF_REQ_BUFF_DEPTH];
    logic [FPW-1:0] hist_ptr;
    logic [FPW:0]   slot_sum;
    logic [FPW-1:0] slot;

    // Match against every occupied FIFO slot and every remembered issued line.
    always_comb begin
        cand_dup = 1'b0;
        slot_sum = '0;
        slot     = '0;
        for (int i = 0; i < PF_REQ_BUFF_DEPTH; i++) begin
            slot_sum = {1'b0, fifo_rd_ptr} + (FPW+1)'(i);
            if (slot_sum >= (FPW+1)'(PF_REQ_BUFF_DEPTH))
                slot_sum = slot_sum - (FPW+1)'(PF_REQ_BUFF_DEPTH);
            slot = slot_sum[FPW-1:0];
            if ((i < int'(fifo_cnt)) && (fifo_mem[slot] == gen_cand)) cand_dup = 1'b1;
            if (hist_vld[i] && (hist_mem[i] == gen_cand)) cand_dup = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || pf_flush) begin
            for (int i = 0; i < PF_REQ_BUFF_DEPTH; i++) begin
                hist_vld[i] <= 1'b0;
                hist_mem[i] <= '0;
            end
            hist_ptr <= '0;
        end else if (pop) begin
            hist_vld[hist_ptr] <= 1'b1;
            hist_mem[hist_ptr] <= pf_req_line;
            hist_ptr <= (hist_ptr == FPW'(PF_REQ_BUFF_DEPTH - 1)) ? '0 : hist_ptr + 1'b1;
        end
    end
`else
    assign cand_dup = 1'b0;
`endif

    assign pf_req_vld  = (fifo_cnt != '0);
    assign pf_req_line = pf_req_vld ? fifo_mem[fifo_rd_ptr] : '0;
    assign pf_busy     = gen_run | pf_req_vld;

endmodule

// File: tb/tb_rrv64_l1d_stride_pf_engine.sv
// Self-checking bench for rrv64_l1d_stride_pf_engine: expected prefetch lines are queued as
// stimulus is driven and compared in order as the DUT hands requests out.
module tb_rrv64_l1d_stride_pf_engine;
  localparam int LW = 50;

  logic          clk = 1'b0;
  logic          rst;
  logic          pf_en;
  logic          pf_flush;
  logic          train_vld;
  logic [15:0]   train_pc;
  logic [55:0]   train_addr;
  logic          pf_req_vld;
  logic          pf_req_rdy;
  logic [LW-1:0] pf_req_line;
  logic          pf_busy;

  logic [LW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_fails  = 0;

  rrv64_l1d_stride_pf_engine dut (
    .clk         (clk),
    .rst         (rst),
    .pf_en       (pf_en),
    .pf_flush    (pf_flush),
    .train_vld   (train_vld),
    .train_pc    (train_pc),
    .train_addr  (train_addr),
    .pf_req_vld  (pf_req_vld),
    .pf_req_rdy  (pf_req_rdy),
    .pf_req_line (pf_req_line),
    .pf_busy     (pf_busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard: every accepted request must be the next expected line
  always @(negedge clk) begin
    if (!rst && pf_req_vld && pf_req_rdy) begin
      if (exp_q.size() == 0) check("unexp_req_vld", {63'd0, pf_req_vld}, 64'd0);
      else check("req_line", {14'd0, pf_req_line}, {14'd0, exp_q.pop_front()});
    end
  end

  // driver tasks
  task automatic train(input logic [15:0] pc, input logic [55:0] addr);
    train_vld  = 1'b1;
    train_pc   = pc;
    train_addr = addr;
    @(posedge clk);
    #1 train_vld = 1'b0;
  endtask

  task automatic train_line(input logic [15:0] pc, input logic [LW-1:0] line);
    train(pc, {line, 6'(($urandom_range(0, 63)))});
  endtask

  task automatic train_run(input logic [15:0] pc, input logic [LW-1:0] first, input int n);
    for (int i = 0; i < n; i++) train_line(pc, first + LW'(i));
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (!pf_busy) break;
    end
    check(tag, {63'd0, pf_busy}, 64'd0);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; pf_en = 1'b1; pf_flush = 1'b0; pf_req_rdy = 1'b1;
    train_vld = 1'b0; train_pc = '0; train_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vld",  {63'd0, pf_req_vld}, 64'd0);
    check("rst_busy", {63'd0, pf_busy}, 64'd0);
    check("rst_line", {14'd0, pf_req_line}, 64'd0);
    rst = 1'b0;
    idle_cycles(2);

    // ascending stride with latency check
    train(16'h12, 56'h1000); train(16'h12, 56'h1040); train(16'h12, 56'h1080);
    train(16'h12, 56'h10C0); train(16'h12, 56'h1100);
    exp_q.push_back(LW'('h45)); exp_q.push_back(LW'('h46)); exp_q.push_back(LW'('h47));
    @(posedge clk); #1;
    check("lat_vld_t1", {63'd0, pf_req_vld}, 64'd0);
    @(posedge clk); #1;
    check("lat_vld_t2", {63'd0, pf_req_vld}, 64'd1);
    check("lat_line_t2", {14'd0, pf_req_line}, 64'h45);
    wait_idle("idle_pos");

    // descending stride
    train(16'h3, 56'h2F00); train(16'h3, 56'h2EC0); train(16'h3, 56'h2E80);
    train(16'h3, 56'h2E40); train(16'h3, 56'h2E00);
    exp_q.push_back(LW'('hB7)); exp_q.push_back(LW'('hB6)); exp_q.push_back(LW'('hB5));
    wait_idle("idle_neg");

    // page boundary cuts generation after 0x3F
    train_run(16'h7, LW'('h3A), 5);
    exp_q.push_back(LW'('h3F));
    wait_idle("idle_page");
    check("page_q_empty", 64'(exp_q.size()), 64'd0);

    // backpressure: second trigger stalls on a full FIFO
    pf_req_rdy = 1'b0;
    train_run(16'h31, LW'('h300), 5);
    train_run(16'h32, LW'('h400), 5);
    foreach (exp_q[i]) check("bp_q_pre_empty", 64'(exp_q[i]), 64'hFFFF);
    exp_q.push_back(LW'('h305)); exp_q.push_back(LW'('h306)); exp_q.push_back(LW'('h307));
    exp_q.push_back(LW'('h405)); exp_q.push_back(LW'('h406)); exp_q.push_back(LW'('h407));
    idle_cycles(4);
    check("bp_busy", {63'd0, pf_busy}, 64'd1);
    check("bp_vld",  {63'd0, pf_req_vld}, 64'd1);
    check("bp_line_hold", {14'd0, pf_req_line}, 64'h305);
    idle_cycles(3);
    check("bp_line_hold2", {14'd0, pf_req_line}, 64'h305);
    pf_req_rdy = 1'b1;
    wait_idle("idle_bp");
    check("bp_q_empty", 64'(exp_q.size()), 64'd0);

    // replacement: fifth PC evicts entry 0, evicted PC retrains from scratch
    pf_flush = 1'b1; @(posedge clk); #1 pf_flush = 1'b0;
    train_run(16'h21, LW'('h100), 4);
    for (int i = 0; i < 4; i++) train_line(16'h22 + 16'(i), LW'('h800 + 16 * i));
    train_line(16'h21, LW'('h104));
    idle_cycles(4);
    check("evict_no_trigger", {63'd0, pf_busy}, 64'd0);
    train_run(16'h21, LW'('h105), 4);
    exp_q.push_back(LW'('h109)); exp_q.push_back(LW'('h10A)); exp_q.push_back(LW'('h10B));
    wait_idle("idle_evict");

    // flush during generation with one queued entry
    pf_req_rdy = 1'b0;
    train_run(16'h41, LW'('h500), 5);
    @(posedge clk); @(posedge clk); #1;
    check("fl_pre_vld",  {63'd0, pf_req_vld}, 64'd1);
    check("fl_pre_line", {14'd0, pf_req_line}, 64'h505);
    pf_flush = 1'b1;
    @(posedge clk); #1 pf_flush = 1'b0;
    check("fl_vld",  {63'd0, pf_req_vld}, 64'd0);
    check("fl_busy", {63'd0, pf_busy}, 64'd0);
    pf_req_rdy = 1'b1;
    train_line(16'h41, LW'('h505));
    idle_cycles(4);
    check("fl_table_invalid", {63'd0, pf_busy}, 64'd0);

    // disabled engine ignores training
    pf_en = 1'b0;
    train_run(16'h51, LW'('h600), 5);
    idle_cycles(3);
    pf_en = 1'b1;
    train_line(16'h51, LW'('h605));
    idle_cycles(4);
    check("en_off_ignored", {63'd0, pf_busy}, 64'd0);

    // overlapping triggers
    train_run(16'h61, LW'('h1FC), 5);
    exp_q.push_back(LW'('h201)); exp_q.push_back(LW'('h202)); exp_q.push_back(LW'('h203));
    wait_idle("idle_ovl_a");
    train_run(16'h62, LW'('h1FD), 5);
`ifndef RRV64_PF_DEDUP_EN
    exp_q.push_back(LW'('h202)); exp_q.push_back(LW'('h203));
`endif
    exp_q.push_back(LW'('h204));
    wait_idle("idle_ovl_b");

    check("final_q_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
